// File: rtl/game_pkg.sv
// Shared game definitions: state encodings used by the sequencer and the
// display controller, BCD digit constants and a binary-to-BCD helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GAMEOVER  = 3'd3
  } game_state_e;

  localparam int              BCD_W       = 4;
  localparam logic [BCD_W-1:0] BLANK_DIGIT = 4'hF;

  // Two-digit BCD for 0..99, used for parameter conversion at elaboration.
  function automatic logic [2*BCD_W-1:0] to_bcd8(input int unsigned v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(v / 10);
    ones = BCD_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/hit inputs and display-facing outputs of the game sequencer.
// Inputs are single-cycle pulses; outputs are registered levels (no handshake).
interface game_sequencer_if;
  logic       start_btn;
  logic       abort_btn;
  logic       hit_pulse;
  logic [2:0] current_state;
  logic [3:0] countdown_timer;
  logic [7:0] game_timer_bcd;
  logic [7:0] score_bcd;
  logic       play_start;

  modport master (
    output start_btn, abort_btn, hit_pulse,
    input  current_state, countdown_timer, game_timer_bcd, score_bcd, play_start
  );

  modport slave (
    input  start_btn, abort_btn, hit_pulse,
    output current_state, countdown_timer, game_timer_bcd, score_bcd, play_start
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick on the last
// count; clear restarts it so the next tick is a full period away.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int               CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_sequencer.sv
// Master game FSM: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER, producing the
// countdown, BCD play timer and BCD score shown on the seven-segment display.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int COUNT_START = 5,
  parameter int GAME_SECS   = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  game_sequencer_if.slave bus
);
  localparam logic [7:0] GAME_BCD = to_bcd8(GAME_SECS);
  localparam logic [3:0] CD_START = 4'(COUNT_START);

  game_state_e state_q, state_d;
  logic [3:0]  cd_q, cd_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  score_q, score_d;
  logic        play_start_q, play_start_d;
  logic        tick;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Any state change restarts the second so each state gets full ticks.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_d != state_q),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    timer_d      = timer_q;
    score_d      = score_q;
    play_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cd_d    = 4'd0;
        timer_d = GAME_BCD;
        score_d = 8'h00;
        if (bus.start_btn) begin
          state_d = ST_COUNTDOWN;
          cd_d    = CD_START;
        end
      end
      ST_COUNTDOWN: begin
        if (bus.abort_btn) begin
          state_d = ST_IDLE;
          cd_d    = 4'd0;
          timer_d = GAME_BCD;
          score_d = 8'h00;
        end else if (tick) begin
          if (cd_q > 4'd1) begin
            cd_d = cd_q - 4'd1;
          end else begin
            state_d      = ST_PLAY;
            cd_d         = 4'd0;
            timer_d      = GAME_BCD;
            score_d      = 8'h00;
            play_start_d = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (bus.abort_btn) begin
          state_d = ST_IDLE;
          timer_d = GAME_BCD;
          score_d = 8'h00;
        end else begin
          if (bus.hit_pulse && score_q != 8'h99) score_d = bcd_inc(score_q);
          if (tick) begin
            if (timer_q <= 8'h01) begin
              timer_d = 8'h00;
              state_d = ST_GAMEOVER;
            end else begin
              timer_d = bcd_dec(timer_q);
            end
          end
        end
      end
      ST_GAMEOVER: begin
        if (bus.start_btn) begin
          state_d = ST_IDLE;
          timer_d = GAME_BCD;
          score_d = 8'h00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cd_d    = 4'd0;
        timer_d = GAME_BCD;
        score_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cd_q         <= 4'd0;
      timer_q      <= GAME_BCD;
      score_q      <= 8'h00;
      play_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      play_start_q <= play_start_d;
    end
  end

  assign bus.current_state   = state_q;
  assign bus.countdown_timer = cd_q;
  assign bus.game_timer_bcd  = timer_q;
  assign bus.score_bcd       = score_q;
  assign bus.play_start      = play_start_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios plus random button/hit
// traffic, every cycle checked against an integer-valued game model.
module tb_game_sequencer;
  localparam int TICK_DIV    = 4;
  localparam int COUNT_START = 5;
  localparam int GAME_SECS   = 12;
  localparam int SAT_DIV     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if bus ();
  game_sequencer_if sat_bus ();

  game_sequencer #(.TICK_DIV(TICK_DIV), .COUNT_START(COUNT_START), .GAME_SECS(GAME_SECS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // Slower tick so a game lasts long enough to saturate the score.
  game_sequencer #(.TICK_DIV(SAT_DIV), .COUNT_START(COUNT_START), .GAME_SECS(GAME_SECS)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- reference model (plain integers) ----------------
  int m_st, m_cd, m_secs, m_score, m_presc;
  bit m_ps;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cd = 0; m_secs = GAME_SECS; m_score = 0; m_presc = 0; m_ps = 0;
  endtask

  task automatic model_update(input logic s, input logic a, input logic h);
    int nst;
    bit tk;
    tk   = (m_presc == TICK_DIV - 1);
    nst  = m_st;
    m_ps = 0;
    case (m_st)
      0: begin
        m_cd = 0; m_secs = GAME_SECS; m_score = 0;
        if (s) begin nst = 1; m_cd = COUNT_START; end
      end
      1: begin
        if (a) begin
          nst = 0; m_cd = 0; m_secs = GAME_SECS; m_score = 0;
        end else if (tk) begin
          if (m_cd > 1) m_cd--;
          else begin nst = 2; m_cd = 0; m_secs = GAME_SECS; m_score = 0; m_ps = 1; end
        end
      end
      2: begin
        if (a) begin
          nst = 0; m_cd = 0; m_secs = GAME_SECS; m_score = 0;
        end else begin
          if (h && m_score < 99) m_score++;
          if (tk) begin
            m_secs--;
            if (m_secs == 0) nst = 3;
          end
        end
      end
      default: begin
        if (s) begin nst = 0; m_secs = GAME_SECS; m_score = 0; end
      end
    endcase
    m_presc = (nst != m_st || tk) ? 0 : m_presc + 1;
    m_st    = nst;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic check_model();
    chk("state",  {5'b0, bus.current_state},   8'(m_st));
    chk("cd",     {4'b0, bus.countdown_timer}, 8'(m_cd));
    chk("timer",  bus.game_timer_bcd,          bcd(m_secs));
    chk("score",  bus.score_bcd,               bcd(m_score));
    chk("pstart", {7'b0, bus.play_start},      {7'b0, m_ps});
    chk("digits", {7'b0, digits_ok(bus.game_timer_bcd) && digits_ok(bus.score_bcd)}, 8'd1);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic a, input logic h);
    bus.start_btn = s;
    bus.abort_btn = a;
    bus.hit_pulse = h;
    @(posedge clk);
    model_update(s, a, h);
    #1;
    bus.start_btn     = 1'b0;
    bus.abort_btn     = 1'b0;
    bus.hit_pulse     = 1'b0;
    sat_bus.start_btn = 1'b0;
    sat_bus.hit_pulse = 1'b0;
    check_model();
  endtask

  task automatic run_to_state(input logic [2:0] st, input string tag);
    int budget;
    budget = 400;
    while (bus.current_state !== st && budget > 0) begin
      step(0, 0, 0);
      budget--;
    end
    chk(tag, {7'b0, budget > 0}, 8'd1);
  endtask

  task automatic run_to_final_tick(input int secs, input string tag);
    int budget;
    budget = 400;
    while (!(m_secs == secs && m_presc == TICK_DIV - 1) && budget > 0) begin
      step(0, 0, 0);
      budget--;
    end
    chk(tag, {7'b0, budget > 0}, 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start_btn = 0; bus.abort_btn = 0; bus.hit_pulse = 0;
    sat_bus.start_btn = 0; sat_bus.abort_btn = 0; sat_bus.hit_pulse = 0;
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("rst_state", {5'b0, bus.current_state}, 8'd0);
    chk("rst_cd",    {4'b0, bus.countdown_timer}, 8'd0);
    chk("rst_timer", bus.game_timer_bcd, 8'h12);
    chk("rst_score", bus.score_bcd, 8'h00);
    chk("rst_ps",    {7'b0, bus.play_start}, 8'd0);

    // Countdown 5..1 then PLAY
    step(1, 0, 0);
    chk("cd_state", {5'b0, bus.current_state}, 8'd1);
    chk("cd_start", {4'b0, bus.countdown_timer}, 8'd5);
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 4; j++) step(0, 0, 0);
      chk("cd_value", {4'b0, bus.countdown_timer}, 8'(5 - k));
    end
    for (int j = 0; j < 4; j++) step(0, 0, 0);
    chk("play_state", {5'b0, bus.current_state}, 8'd2);
    chk("play_cd",    {4'b0, bus.countdown_timer}, 8'd0);
    chk("play_timer", bus.game_timer_bcd, 8'h12);
    chk("play_ps_hi", {7'b0, bus.play_start}, 8'd1);

    // 13 hits while the timer borrows 12 -> 11 -> 10 -> 09
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1);
      if (i == 0) chk("play_ps_lo", {7'b0, bus.play_start}, 8'd0);
      if (i == 3) chk("timer_11", bus.game_timer_bcd, 8'h11);
      if (i == 7) chk("timer_10", bus.game_timer_bcd, 8'h10);
    end
    chk("score_13", bus.score_bcd, 8'h13);
    chk("timer_09", bus.game_timer_bcd, 8'h09);
    run_to_state(3'd3, "wait_gameover");
    chk("go_timer", bus.game_timer_bcd, 8'h00);
    chk("go_score", bus.score_bcd, 8'h13);
    step(0, 0, 1);
    chk("go_hit_ignored", bus.score_bcd, 8'h13);
    step(1, 0, 0);
    chk("go_to_idle", {5'b0, bus.current_state}, 8'd0);
    chk("idle_score", bus.score_bcd, 8'h00);
    step(0, 0, 1);
    chk("idle_hit_ignored", bus.score_bcd, 8'h00);

    // Hit coinciding with the final tick
    step(1, 0, 0);
    run_to_state(3'd2, "wait_play2");
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    run_to_final_tick(1, "wait_final_tick");
    chk("pre_final_score", bus.score_bcd, 8'h07);
    step(0, 0, 1);
    chk("final_state", {5'b0, bus.current_state}, 8'd3);
    chk("final_score", bus.score_bcd, 8'h08);
    chk("final_timer", bus.game_timer_bcd, 8'h00);

    // Abort with a simultaneous tick at timer 07
    step(1, 0, 0);
    step(1, 0, 0);
    run_to_state(3'd2, "wait_play3");
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    run_to_final_tick(7, "wait_timer07");
    chk("abort_pre_timer", bus.game_timer_bcd, 8'h07);
    step(0, 1, 0);
    chk("abort_state", {5'b0, bus.current_state}, 8'd0);
    chk("abort_score", bus.score_bcd, 8'h00);
    chk("abort_timer", bus.game_timer_bcd, 8'h12);

    // start+abort together in COUNTDOWN
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    chk("start_abort", {5'b0, bus.current_state}, 8'd0);

    // Asynchronous reset between clock edges mid-countdown
    step(1, 0, 0);
    for (int j = 0; j < 6; j++) step(0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_state", {5'b0, bus.current_state}, 8'd0);
    chk("arst_cd",    {4'b0, bus.countdown_timer}, 8'd0);
    chk("arst_timer", bus.game_timer_bcd, 8'h12);
    chk("arst_score", bus.score_bcd, 8'h00);
    chk("arst_ps",    {7'b0, bus.play_start}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1);

    // Score saturation on the slow-tick instance
    sat_bus.start_btn = 1'b1;
    step(0, 0, 0);
    begin
      int budget;
      budget = 200;
      while (sat_bus.current_state !== 3'd2 && budget > 0) begin
        step(0, 0, 0);
        budget--;
      end
      chk("sat_wait_play", {7'b0, budget > 0}, 8'd1);
    end
    for (int i = 0; i < 105; i++) begin
      sat_bus.hit_pulse = 1'b1;
      step(0, 0, 0);
      chk("sat_digits", {7'b0, digits_ok(sat_bus.score_bcd)}, 8'd1);
    end
    chk("sat_score", sat_bus.score_bcd, 8'h99);
    chk("sat_state", {5'b0, sat_bus.current_state}, 8'd2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Master game FSM that sequences the 8-digit seven-segment display controller. It generates the state code, the pre-game countdown, the BCD play timer and the BCD score that the display mux formats. It sits between the debounced button/hit inputs and the display controller in the top level.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s game tick (must be >= 2)
COUNT_START, 5, countdown start value (1..9)
GAME_SECS, 30, play duration in seconds (1..99, converted to BCD internally)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_btn  in  1  single-cycle debounced start/restart pulse
abort_btn  in  1  single-cycle debounced abort pulse
hit_pulse  in  1  single-cycle scoring event
current_state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, GAMEOVER=3
countdown_timer  out  4  binary countdown value 0..COUNT_START
game_timer_bcd  out  8  {tens, ones} BCD seconds remaining
score_bcd  out  8  {tens, ones} BCD score
play_start  out  1  one-cycle pulse on the COUNTDOWN->PLAY transition

Behaviour:
- Reset: one clock, asynchronous active-low reset. All registers clear asynchronously on rst_n=0. Reset values: current_state=IDLE, countdown_timer=0, game_timer_bcd=BCD(GAME_SECS), score_bcd=8'h00, play_start=0, prescaler=0.
- Prescaler: counts 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. It clears to 0 on every state transition, so the first tick in a new state arrives exactly TICK_DIV cycles after entry.
- All outputs are registered. A change is visible the cycle after the triggering input or tick.
- IDLE:
  - Hold score=00 and timer=BCD(GAME_SECS).
  - start_btn -> COUNTDOWN with countdown_timer=COUNT_START.
- COUNTDOWN:
  - On a tick with countdown_timer>1, decrement it.
  - On a tick with countdown_timer==1, go to PLAY. Set countdown_timer=0, load timer with BCD(GAME_SECS), set score=00, pulse play_start.
  - start_btn is ignored.
- PLAY:
  - hit_pulse increments score in BCD: ones 9 -> 0 with a carry into tens. Score saturates at 99 (8'h99); further hits are ignored.
  - On a tick, the timer decrements in BCD: ones 0 -> 9 with a borrow from tens.
  - On a tick with timer==8'h01, the timer becomes 8'h00 and the state goes to GAMEOVER in the same cycle.
  - start_btn is ignored.
- GAMEOVER:
  - Score and timer (00) are frozen.
  - start_btn -> IDLE, which clears the score.
  - hit_pulse is ignored.
- abort_btn in COUNTDOWN or PLAY -> IDLE immediately (next cycle) with IDLE values. It is ignored in IDLE and GAMEOVER.
- Simultaneous events:
  - abort_btn and start_btn together: abort wins.
  - hit_pulse and the final tick in the same cycle: the hit is counted, and GAMEOVER shows the incremented score.
  - abort_btn and a tick together: abort wins, with no decrement.
- hit_pulse outside PLAY never alters the score.
- Undefined state encodings (4..7) recover to IDLE on the next clock.
- No BCD digit may ever hold a value above 9.
- Reset asserted mid-game returns the block to IDLE reset values asynchronously. No tick or play_start fires in the cycle reset is released.

Decomposition:
- Shared package game_pkg holds:
  - state encodings IDLE/COUNTDOWN/PLAY/GAMEOVER (3-bit), also used by display_controller
  - BCD digit width constant
  - blank-digit code 4'hF
- Sub-module tick_prescaler:
  - parameter TICK_DIV
  - ports clk, rst_n, clear, tick
  - counter width $clog2(TICK_DIV)
- BCD increment/decrement stays inline in game_sequencer.

Test Plan (TICK_DIV=4, COUNT_START=5, GAME_SECS=12):
- Reset then start_btn -> state=1, countdown 5; after 4, 8, 12, 16 clk it reads 4, 3, 2, 1; at 20 clk state=2, countdown=0, timer=8'h12, play_start high exactly 1 cycle.
- PLAY: 13 hit_pulses -> score=8'h13; timer decrements 12 -> 11 -> 10 -> 09 (borrow check); at timer 01 plus a tick -> timer=00, state=3.
- Hit and final tick in the same cycle with score=8'h07 -> GAMEOVER with score=8'h08.
- Force 105 hits in PLAY -> score holds 8'h99, no digit >9.
- abort_btn mid-PLAY at timer=8'h07 -> next cycle state=0, score=00, timer=8'h12; start_btn and abort_btn together in COUNTDOWN -> IDLE.
- rst_n pulsed low mid-COUNTDOWN asynchronously (between clock edges) -> outputs at reset values immediately; hit_pulse in IDLE/GAMEOVER leaves score unchanged.
